// File: rtl/palette_quantizer.sv
// Maps a 24-bit colour to the nearest entry of the fixed 8-entry VGA palette,
// searching one entry per clock and reporting the index and Manhattan distance.
module palette_quantizer #(
  parameter int unsigned SWAP_IN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] pixel_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  index_out,
  output logic [9:0]  dist_out
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [2:0]  index_q;
  logic [9:0]  dist_q;
  logic [7:0]  r_q, g_q, b_q;
  logic [2:0]  idx_q;
  logic [2:0]  best_idx_q;
  logic [9:0]  best_q;

  logic [7:0]  px_r, px_g, px_b;
  logic [23:0] entry;
  logic [9:0]  d;
  logic        take;
  logic [9:0]  best_d;
  logic [2:0]  best_idx_d;

  // Palette entries packed as {R,G,B}
  function automatic logic [23:0] pal(input logic [2:0] i);
    case (i)
      3'd0:    pal = 24'h000000;
      3'd1:    pal = 24'h030326;
      3'd2:    pal = 24'h0a0a46;
      3'd3:    pal = 24'h38383a;
      3'd4:    pal = 24'h2d2621;
      3'd5:    pal = 24'h000000;
      3'd6:    pal = 24'h241211;
      default: pal = 24'h645f57;
    endcase
  endfunction

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    absdiff = (a > b) ? (a - b) : (b - a);
  endfunction

  assign px_r = (SWAP_IN != 0) ? pixel_in[7:0]   : pixel_in[23:16];
  assign px_g = pixel_in[15:8];
  assign px_b = (SWAP_IN != 0) ? pixel_in[23:16] : pixel_in[7:0];

  // Strict less-than keeps the lowest index on ties
  always_comb begin
    entry      = pal(idx_q);
    d          = {2'b00, absdiff(r_q, entry[23:16])}
               + {2'b00, absdiff(g_q, entry[15:8])}
               + {2'b00, absdiff(b_q, entry[7:0])};
    take       = (d < best_q);
    best_d     = take ? d : best_q;
    best_idx_d = take ? idx_q : best_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      index_q     <= '0;
      dist_q      <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            r_q        <= px_r;
            g_q        <= px_g;
            b_q        <= px_b;
            idx_q      <= '0;
            best_q     <= '1;
            best_idx_q <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SEARCH;
          end
        end
        SEARCH: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          idx_q      <= idx_q + 3'd1;
          // Last entry is folded into the result on the same edge
          if (idx_q == 3'd7) begin
            index_q     <= best_idx_d;
            dist_q      <= best_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign index_out = index_q;
  assign dist_out  = dist_q;

endmodule

// File: tb/tb_palette_quantizer.sv
// Directed bench for palette_quantizer: latency, tie-break, backpressure and
// mid-search reset, with hand-computed expected index/distance values.
module tb_palette_quantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] pixel_in;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  index_out;
  logic [9:0]  dist_out;

  int total = 0;
  int bad   = 0;

  palette_quantizer #(.SWAP_IN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel_in  (pixel_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .index_out (index_out),
    .dist_out  (dist_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Accepts px, scrambles pixel_in during search, checks exact 8-edge latency,
  // result, handshake and that the result is held afterwards.
  task automatic run_pixel(input string tag, input logic [23:0] px,
                           input logic [2:0] exp_idx, input logic [9:0] exp_dist);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    pixel_in = px;
    tick();
    in_valid = 1'b0;
    pixel_in = ~px;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_index"}, 32'(index_out), 32'(exp_idx));
    check({tag, "_dist"},  32'(dist_out),  32'(exp_dist));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle({tag, "_hs"});
    check({tag, "_hold_index"}, 32'(index_out), 32'(exp_idx));
    check({tag, "_hold_dist"},  32'(dist_out),  32'(exp_dist));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pixel_in  = '0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_index", 32'(index_out), 32'd0);
    check("reset_dist",  32'(dist_out),  32'd0);

    run_pixel("exact7",  24'h575f64, 3'd7, 10'd0);
    run_pixel("black",   24'h000000, 3'd0, 10'd0);
    run_pixel("tie01",   24'h160000, 3'd0, 10'd22);
    run_pixel("white",   24'hffffff, 3'd7, 10'd483);
    run_pixel("blueish", 24'h300505, 3'd1, 10'd14);

    // Backpressure: result held while out_ready low, new pixel not accepted
    in_valid = 1'b1;
    pixel_in = 24'h575f64;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    pixel_in = 24'hffffff;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_index", 32'(index_out), 32'd7);
      check("bp_hold_dist",  32'(dist_out),  32'd0);
      check("bp_no_accept",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("bp_release");
    tick();
    in_valid = 1'b0;
    pixel_in = 24'h000000;
    check("bp_accepted", 32'(in_ready), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("bp_early", 32'(out_valid), 32'd0);
    tick();
    check("bp2_valid", 32'(out_valid), 32'd1);
    check("bp2_index", 32'(index_out), 32'd7);
    check("bp2_dist",  32'(dist_out),  32'd483);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("bp2_hs");

    // Reset in the 4th search cycle discards the partial search
    in_valid = 1'b1;
    pixel_in = 24'h300505;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_index", 32'(index_out), 32'd0);
    check("midrst_dist",  32'(dist_out),  32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("midrst_no_result", 32'(out_valid), 32'd0);
    run_pixel("after_rst", 24'h575f64, 3'd7, 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/palette_quantizer.md
Name: palette_quantizer

Overview:
- Inverse of the 3-bit palette colour decoder in the VGA graphics path.
- Accepts a 24-bit pixel colour and returns the 3-bit index of the nearest entry in the fixed 8-entry palette, plus the distance to that entry.
- Used by the frame-capture and sprite-import path to pack true-colour pixels into 3-bit framebuffer words.
- Sequential search: one palette entry is compared per clock, with valid/ready handshakes on both sides.

Parameters:
- SWAP_IN, 1: 1 = pixel byte order is {B,G,R} (B in [23:16], R in [7:0]), the same order the decoder drives; 0 = {R,G,B}.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pixel_in is valid
- in_ready  out  1  block can accept a pixel
- pixel_in  in  24  pixel colour, byte order per SWAP_IN
- out_valid  out  1  result is valid
- out_ready  in  1  downstream accepts the result
- index_out  out  3  nearest palette index
- dist_out  out  10  Manhattan distance to the chosen entry

Behaviour:
- Palette, fixed, given as R,G,B hex:
  - 0: 00,00,00
  - 1: 03,03,26
  - 2: 0a,0a,46
  - 3: 38,38,3a
  - 4: 2d,26,21
  - 5: 00,00,00
  - 6: 24,12,11
  - 7: 64,5f,57
- One clock domain, clk; rst is synchronous and active-high.
- Reset: state=IDLE; in_ready=1; out_valid=0; index_out=0; dist_out=0; internal best/idx/latched pixel cleared.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch pixel_in un-swapped to internal R,G,B, set idx=0, best_dist=10'h3FF, best_idx=0, then go to SEARCH.
  - SEARCH: in_ready=0. Each cycle compute d = |R-Pr[idx]| + |G-Pg[idx]| + |B-Pb[idx]|, 10-bit unsigned, max 765. If d < best_dist (strict), update best_dist=d and best_idx=idx. Increment idx. After the edge that evaluates idx=7, go to DONE and load index_out/dist_out from the final best, including a compare of entry 7 on that same edge.
  - DONE: out_valid=1; index_out/dist_out held stable. On out_ready, out_valid drops and state goes to IDLE on the next edge.
- Latency: out_valid rises exactly 8 clock edges after the accepting edge. Minimum accept-to-accept spacing is 10 cycles when out_ready is held high.
- Ties resolve to the lowest index; the strict compare guarantees this. Black therefore always maps to 0, never 5.
- No early termination on d=0; latency is fixed.
- in_valid while not IDLE is ignored; pixel_in is sampled only on the accepting edge. Changes to pixel_in during SEARCH have no effect.
- out_ready while not in DONE is ignored. out_valid stays high indefinitely while out_ready=0, with outputs unchanged.
- index_out/dist_out hold their last result after handshake until the next DONE.
- rst asserted in any state, including mid-SEARCH and DONE with out_ready=0, restores reset values on that edge. The partial search is discarded and no result is emitted.
- Subtraction uses 9-bit signed intermediates or compare-and-swap; the sum is zero-extended to 10 bits with no overflow.

Test Plan:
- SWAP_IN=1, pixel_in=24'h575f64 -> 8 edges after accept: out_valid=1, index_out=7, dist_out=0.
- pixel_in=24'h000000 -> index_out=0 (not 5), dist_out=0. Tie-break check.
- pixel_in=24'h160000 (R=00,G=00,B=16) -> entries 0 and 1 both at distance 22 -> index_out=0, dist_out=22.
- pixel_in=24'hffffff -> index_out=7, dist_out=483. pixel_in=24'h300505 -> index_out=1, dist_out=14.
- Backpressure: hold out_ready=0 for 20 cycles after DONE, then drive in_valid with a new pixel -> out_valid and outputs stable throughout, in_ready=0, no accept. Raise out_ready -> out_valid=0 next cycle, in_ready=1, then the new pixel is accepted.
- Reset at the 4th SEARCH cycle -> next cycle state is IDLE, in_ready=1, out_valid=0, index_out=0, dist_out=0. A following pixel 24'h575f64 yields index 7 with normal latency.
